// File: rtl/mdu_ctrl_if.sv
// Command/result bundle between the E-stage issue logic and the MD sequencer.
// The master drives a command strobe with operands; the slave returns
// busy, the mfhi/mflo read value and the architectural HI/LO registers.
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] v1;
  logic [31:0] v2;
  logic        busy;
  logic [31:0] res;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdu_op, v1, v2, input busy, res, hi, lo);
  modport slave  (input start, mdu_op, v1, v2, output busy, res, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage.
// The result is computed at the accept edge into pending registers and
// committed to HI/LO once a down-counter models the unit latency.
// Optional build macro: MDU_MADD_EN enables madd/maddu/msub/msubu (ops 9-12);
// without it those opcodes behave as reserved and the accumulate adders
// are not built.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_p_hi;
  logic [31:0] r_p_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_multi;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic [31:0] w_dvs;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;

  // Multi-cycle opcodes are the ones that raise busy and load the counter.
  always_comb begin
    w_multi = (bus.mdu_op >= OP_MULT) && (bus.mdu_op <= OP_DIVU);
`ifdef MDU_MADD_EN
    if (bus.mdu_op >= OP_MADD && bus.mdu_op <= OP_MSUBU) w_multi = 1'b1;
`endif
  end

  // Full 64-bit products; sign-extend to 64 bits so the low 64 product bits are exact.
  assign w_prod_s = $signed({{32{bus.v1[31]}}, bus.v1}) * $signed({{32{bus.v2[31]}}, bus.v2});
  assign w_prod_u = {32'd0, bus.v1} * {32'd0, bus.v2};

  // The divider never sees zero or the INT_MIN/-1 overflow pair; those are handled by muxing.
  assign w_div_zero = (bus.v2 == 32'd0);
  assign w_div_ovf  = (bus.v1 == 32'h8000_0000) && (bus.v2 == 32'hFFFF_FFFF);
  assign w_dvs      = (w_div_zero || w_div_ovf) ? 32'd1 : bus.v2;
  assign w_q_s      = w_div_ovf ? 32'h8000_0000 : 32'($signed(bus.v1) / $signed(w_dvs));
  assign w_r_s      = w_div_ovf ? 32'd0 : 32'($signed(bus.v1) % $signed(w_dvs));
  assign w_q_u      = bus.v1 / w_dvs;
  assign w_r_u      = bus.v1 % w_dvs;

`ifdef MDU_MADD_EN
  logic [63:0] w_madd_s;
  logic [63:0] w_madd_u;
  logic [63:0] w_msub_s;
  logic [63:0] w_msub_u;
  assign w_madd_s = {r_hi, r_lo} + w_prod_s;
  assign w_madd_u = {r_hi, r_lo} + w_prod_u;
  assign w_msub_s = {r_hi, r_lo} - w_prod_s;
  assign w_msub_u = {r_hi, r_lo} - w_prod_u;
`endif

  // Sequencer: accept a command when idle, count down while running, commit at cnt==1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_p_hi  <= 32'd0;
      r_p_lo  <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_hi    <= r_p_hi;
        r_lo    <= r_p_lo;
        r_state <= ST_IDLE;
      end
    end else if (bus.start) begin
      if (w_multi) r_state <= ST_RUN;
      case (bus.mdu_op)
        OP_MULT: begin
          {r_p_hi, r_p_lo} <= w_prod_s;
          r_cnt            <= 4'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {r_p_hi, r_p_lo} <= w_prod_u;
          r_cnt            <= 4'(MULT_CYCLES);
        end
        OP_DIV: begin
          r_p_hi <= w_div_zero ? r_hi : w_r_s;
          r_p_lo <= w_div_zero ? r_lo : w_q_s;
          r_cnt  <= 4'(DIV_CYCLES);
        end
        OP_DIVU: begin
          r_p_hi <= w_div_zero ? r_hi : w_r_u;
          r_p_lo <= w_div_zero ? r_lo : w_q_u;
          r_cnt  <= 4'(DIV_CYCLES);
        end
        OP_MTHI: r_hi <= bus.v1;
        OP_MTLO: r_lo <= bus.v1;
`ifdef MDU_MADD_EN
        OP_MADD: begin
          {r_p_hi, r_p_lo} <= w_madd_s;
          r_cnt            <= 4'(MULT_CYCLES);
        end
        OP_MADDU: begin
          {r_p_hi, r_p_lo} <= w_madd_u;
          r_cnt            <= 4'(MULT_CYCLES);
        end
        OP_MSUB: begin
          {r_p_hi, r_p_lo} <= w_msub_s;
          r_cnt            <= 4'(MULT_CYCLES);
        end
        OP_MSUBU: begin
          {r_p_hi, r_p_lo} <= w_msub_u;
          r_cnt            <= 4'(MULT_CYCLES);
        end
`endif
        default: ;
      endcase
    end
  end

  // Hazard stall and mfhi/mflo read path are purely combinational.
  always_comb begin
    bus.busy = (bus.start && w_multi) || (r_cnt != 4'd0);
    bus.res  = 32'd0;
    if (bus.mdu_op == OP_MFHI) bus.res = r_hi;
    else if (bus.mdu_op == OP_MFLO) bus.res = r_lo;
  end

  assign bus.hi = r_hi;
  assign bus.lo = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency/busy timing, mult/div results,
// divide-by-zero and overflow, mthi/mtlo/mfhi/mflo, ignored start,
// mid-operation reset, back-to-back issue, and ops 9-12 with or without
// MDU_MADD_EN.
module tb_mdu_ctrl;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command for one cycle, check busy in the start cycle, then release.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic exp_busy);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.v1     = a;
    bus.v2     = b;
    #1;
    check({tag, " start-busy"}, {31'd0, bus.busy}, {31'd0, exp_busy});
    tick();
    bus.start  = 1'b0;
    bus.mdu_op = 4'd0;
    $display("[TB] issue %s op=%0d v1=%h v2=%h", tag, op, a, b);
  endtask

  // Busy must stay high for n cycles after accept, HI/LO frozen, then drop with the commit.
  task automatic run(input string tag, input int n, input logic [31:0] old_hi,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
      check({tag, " hi-held"}, bus.hi, old_hi);
      tick();
    end
    check({tag, " busy-done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " hi"}, bus.hi, exp_hi);
    check({tag, " lo"}, bus.lo, exp_lo);
    $display("[TB] commit %s hi=%h lo=%h", tag, bus.hi, bus.lo);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.mdu_op = 4'd0;
    bus.v1     = 32'd0;
    bus.v2     = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset res", bus.res, 32'd0);

    // mult / multu
    issue("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    run("mult", 5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    run("multu", 5, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);

    // div / divu, including zero divisor and signed overflow
    issue("div-7/2", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run("div-7/2", 10, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue("divu/0", 4'd4, 32'd7, 32'd0, 1'b1);
    run("divu/0", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue("div7/-2", 4'd3, 32'd7, 32'hFFFF_FFFE, 1'b1);
    run("div7/-2", 10, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFD);
    issue("divu100/7", 4'd4, 32'd100, 32'd7, 1'b1);
    run("divu100/7", 10, 32'h0000_0001, 32'd2, 32'd14);
    issue("div-ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run("div-ovf", 10, 32'd2, 32'd0, 32'h8000_0000);

    // mthi/mtlo zero latency; mfhi/mflo combinational without start
    issue("mthi", 4'd5, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi busy", {31'd0, bus.busy}, 32'd0);
    check("mthi hi", bus.hi, 32'h1234_5678);
    check("mthi lo-kept", bus.lo, 32'h8000_0000);
    bus.mdu_op = 4'd7;
    #1;
    check("mfhi res", bus.res, 32'h1234_5678);
    check("mfhi busy", {31'd0, bus.busy}, 32'd0);
    bus.mdu_op = 4'd8;
    #1;
    check("mflo res", bus.res, 32'h8000_0000);
    bus.mdu_op = 4'd0;
    issue("mtlo", 4'd6, 32'hCAFE_F00D, 32'd0, 1'b0);
    check("mtlo lo", bus.lo, 32'hCAFE_F00D);
    check("mtlo hi-kept", bus.hi, 32'h1234_5678);

    // start during a running div is ignored
    issue("div100/7", 4'd3, 32'd100, 32'd7, 1'b1);
    tick();
    tick();
    issue("ign-mult", 4'd1, 32'd3, 32'd3, 1'b1);
    run("div100/7", 7, 32'h1234_5678, 32'd2, 32'd14);

    // reset in the third cycle of a mult
    issue("mult-rst", 4'd1, 32'd3, 32'd4, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst hi", bus.hi, 32'd0);
    check("rst lo", bus.lo, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("rst no-commit lo", bus.lo, 32'd0);
    check("rst no-commit busy", {31'd0, bus.busy}, 32'd0);

    // back-to-back: second mult issued in the cycle cnt has just reached 0
    issue("mult3*4", 4'd1, 32'd3, 32'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("b2b busy1", {31'd0, bus.busy}, 32'd1);
      tick();
    end
    check("b2b first lo", bus.lo, 32'd12);
    issue("mult5*6", 4'd1, 32'd5, 32'd6, 1'b1);
    run("mult5*6", 5, 32'd0, 32'd0, 32'd30);

`ifdef MDU_MADD_EN
    issue("mthi0", 4'd5, 32'd0, 32'd0, 1'b0);
    issue("mtloF", 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue("maddu", 4'd10, 32'd1, 32'd1, 1'b1);
    run("maddu", 5, 32'd0, 32'd1, 32'd0);
    issue("mthi0b", 4'd5, 32'd0, 32'd0, 1'b0);
    issue("mtlo0", 4'd6, 32'd0, 32'd0, 1'b0);
    issue("msub", 4'd11, 32'd1, 32'd1, 1'b1);
    run("msub", 5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    issue("mthiA", 4'd5, 32'hAAAA_5555, 32'd0, 1'b0);
    issue("op9", 4'd9, 32'd1, 32'd1, 1'b0);
    check("op9 busy", {31'd0, bus.busy}, 32'd0);
    check("op9 hi", bus.hi, 32'hAAAA_5555);
    check("op9 lo", bus.lo, 32'd30);
    tick();
    check("op9 busy later", {31'd0, bus.busy}, 32'd0);
    check("op9 lo later", bus.lo, 32'd30);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide sequencer for the P6 pipeline; sits in the E stage beside the ALU.
- Accepts one multiply/divide/move-to-HI/LO command per strobe and computes the result internally.
- Models multi-cycle latency with a down-counter and commits to architectural HI/LO only when the latency expires.
- Exports `busy` so the hazard unit can stall dependent MD instructions, and returns HI/LO for `mfhi`/`mflo`.

Parameters:
- MULT_CYCLES, 5, latency in cycles of mult/multu (and madd family); legal range 1..15.
- DIV_CYCLES, 10, latency in cycles of div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command valid strobe, one cycle per instruction.
- mdu_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 reserved.
- v1  input  32  rs operand (dividend / multiplicand / mthi/mtlo source).
- v2  input  32  rt operand (divisor / multiplier).
- busy  output  1  `start & (mdu_op in 1..4, 9..12)` OR `cnt != 0`; combinational.
- res  output  32  combinational: `hi` when mdu_op==7, `lo` when mdu_op==8, else 0.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset (synchronous): `cnt`=0, `hi`=0, `lo`=0, pending registers=0; `busy`=0 the cycle after reset is sampled. Reset mid-operation discards the pending result; HI/LO do not commit.
- Internal state: `cnt` (4 bits), `p_hi` and `p_lo` (32 bits each).
- States:
  - IDLE (`cnt`==0).
  - RUN (`cnt`!=0): `cnt` decrements every edge; on the edge where `cnt`==1, `hi<=p_hi`, `lo<=p_lo`, `cnt<=0`.
- Accept rule: a command is accepted at an edge where `start`=1 and `cnt`==0. Any `start` while `cnt`!=0 is ignored entirely (the hazard unit guarantees this does not occur). mdu_op 0, 7, 8 and 13-15 never change state.
- mult (signed) / multu (unsigned):
  - Full 64-bit product {p_hi,p_lo} captured at the accept edge.
  - `cnt<=MULT_CYCLES`.
  - HI/LO observable MULT_CYCLES edges after the accept edge.
- div/divu:
  - `p_lo`=quotient, `p_hi`=remainder; `cnt<=DIV_CYCLES`.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.
- Divisor zero: `cnt` still loads DIV_CYCLES and `busy` behaves normally, but `p_hi`/`p_lo` load the current `hi`/`lo`, so HI/LO stay unchanged.
- mthi/mtlo: `hi<=v1` (resp. `lo<=v1`) at the accept edge; zero latency; `cnt` unchanged (0).
- mfhi/mflo: purely combinational read of committed `hi`/`lo`. They never see an uncommitted pending value, and need no `start`.
- `busy` goes high in the same cycle as an accepted multi-cycle `start`. Back-to-back: a new command can be accepted in the cycle where `cnt` has just become 0.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Ops 9-12 accepted with latency MULT_CYCLES.
  - madd/maddu: `{p_hi,p_lo} = {hi,lo} + v1*v2` (signed / unsigned product).
  - msub/msubu: `{p_hi,p_lo} = {hi,lo} - v1*v2`.
  - 64-bit arithmetic wraps modulo 2^64.
- Not defined: ops 9-12 are treated as reserved (no state change, `busy` not asserted), and the madd adder logic is absent.

Test Plan:
- mult, v1=0xFFFFFFFF, v2=2 -> `busy` high for 5 cycles from the start cycle; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div, v1=-7 (0xFFFFFFF9), v2=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, v1=7, v2=0 -> `busy` 10 cycles, hi/lo keep their prior values.
- mthi v1=0x12345678, then mflo/mfhi next cycle -> res=0x12345678 for mfhi with zero busy. Second `start` (mult) issued while a div is running -> ignored; the div result commits unaltered.
- Reset asserted at cycle 3 of a mult -> next cycle `busy`=0, hi=lo=0, and no commit ever occurs. mult accepted the cycle `cnt` reaches 0 -> `busy` continuous, both results commit in order.
- (MDU_MADD_EN) hi=0, lo=0xFFFFFFFF, maddu v1=1, v2=1 -> hi=1, lo=0. msub v1=1, v2=1 from hi=lo=0 -> hi=lo=0xFFFFFFFF. Without the macro, op 9 -> `busy`=0 and HI/LO unchanged.
